// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide mode-0 SPI master (MSB first) for SD card pins.
module sd_spi_master #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           wr_data,
  input  logic                 wr_stb,
  input  logic                 cs_set,
  input  logic                 cs_val,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 sd_sck,
  output logic                 sd_mosi,
  input  logic                 sd_miso,
  output logic                 sd_cs_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] half_q, half_d, reload_q, reload_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           tx_q, tx_d, rx_q, rx_d, rd_data_q, rd_data_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      half_q    <= '0;
      reload_q  <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      reload_q  <= reload_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    reload_d  = reload_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    case (state_q)
      IDLE: begin
        cs_d = cs_set ? cs_val : cs_q;
        if (wr_stb) begin
          reload_d = div;
          half_d   = div;
          tx_d     = wr_data;
          mosi_d   = wr_data[7];
          bit_d    = '0;
          busy_d   = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        half_d = half_q - 1'b1;
        if (half_q == '0) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], sd_miso};
          half_d  = reload_q;
          state_d = HIGH;
        end
      end
      HIGH: begin
        half_d = half_q - 1'b1;
        if (half_q == '0) begin
          sck_d  = 1'b0;
          half_d = reload_q;
          if (bit_q != 3'd7) begin
            mosi_d  = tx_q[6];
            tx_d    = {tx_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end else begin
            rd_data_d = rx_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            mosi_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sd_sck  = sck_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_q;
endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed bench for sd_spi_master with per-scenario tasks.
module tb_sd_spi_master;
  logic       clk_core = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_stb = 1'b0;
  logic       cs_set = 1'b0;
  logic       cs_val = 1'b1;
  logic [7:0] rd_data;
  logic       busy, done, sd_sck, sd_mosi, sd_cs_n, sd_miso;
  logic       loop_en = 1'b0;
  logic       miso_val = 1'b0;
  int         checks = 0;
  int         failures = 0;
  assign sd_miso = loop_en ? sd_mosi : miso_val;
  always #5 clk_core = ~clk_core;
  sd_spi_master #(.DIV_WIDTH(8)) dut (
    .clk_core(clk_core), .reset_n(reset_n), .div(div), .wr_data(wr_data),
    .wr_stb(wr_stb), .cs_set(cs_set), .cs_val(cs_val), .rd_data(rd_data),
    .busy(busy), .done(done), .sd_sck(sd_sck), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
  );
  task automatic upd(input logic v, input int len, inout int lmin, inout int lmax,
                     inout int hmin, inout int hmax);
    if (v) begin
      if (len < hmin) hmin = len;
      if (len > hmax) hmax = len;
    end else begin
      if (len < lmin) lmin = len;
      if (len > lmax) lmax = len;
    end
  endtask
  // Starts at a negedge, returns at the negedge of the first cycle with busy low.
  task automatic xfer(input logic [7:0] d, input logic cs_s, input logic cs_v, input int inj,
                      output int bc, output logic [7:0] mb, output int lmin, output int lmax,
                      output int hmin, output int hmax, output int unstable,
                      output logic done_end, output logic cs_first, output logic busy_first);
    logic prev_sck, prev_mosi, run_val;
    int   run_len;
    wr_data = d; wr_stb = 1'b1; cs_set = cs_s; cs_val = cs_v;
    @(negedge clk_core);
    wr_stb = 1'b0; cs_set = 1'b0;
    cs_first = sd_cs_n; busy_first = busy;
    bc = 0; mb = 8'h00; unstable = 0;
    lmin = 1 << 30; hmin = 1 << 30; lmax = 0; hmax = 0;
    prev_sck = 1'b0; prev_mosi = sd_mosi; run_val = sd_sck; run_len = 0;
    while (busy === 1'b1 && bc < 5000) begin
      bc++;
      if (sd_sck === run_val) run_len++;
      else begin
        upd(run_val, run_len, lmin, lmax, hmin, hmax);
        run_val = sd_sck; run_len = 1;
      end
      if (sd_sck && !prev_sck) begin
        mb = {mb[6:0], sd_mosi};
        if (sd_mosi !== prev_mosi) unstable++;
      end
      prev_sck = sd_sck; prev_mosi = sd_mosi;
      if (bc - 1 == inj) begin
        wr_stb = 1'b1; wr_data = 8'hFF; cs_set = 1'b1; cs_val = 1'b1; div = 8'd7;
      end else begin
        wr_stb = 1'b0; cs_set = 1'b0;
      end
      @(negedge clk_core);
    end
    upd(run_val, run_len, lmin, lmax, hmin, hmax);
    done_end = done;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk_core);
    checks++;
    if ({sd_sck, sd_mosi, sd_cs_n, busy, done, rd_data} !== {5'b01100, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got sck=%b mosi=%b cs_n=%b busy=%b done=%b rd=%h want 0 1 1 0 0 00",
               sd_sck, sd_mosi, sd_cs_n, busy, done, rd_data);
    end
    reset_n = 1'b1;
    @(negedge clk_core);
  endtask
  task automatic test_loopback;
    int bc, lmin, lmax, hmin, hmax, uns;
    logic [7:0] mb;
    logic de, cf, bf;
    div = 8'd0; loop_en = 1'b1;
    xfer(8'hA5, 1'b0, 1'b0, -1, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++; if (bc !== 16) begin failures++; $display("FAIL loop_busy_len got %0d want 16", bc); end
    checks++; if (de !== 1'b1) begin failures++; $display("FAIL loop_done got %b want 1", de); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL loop_rd got %h want a5", rd_data); end
    checks++; if (mb !== 8'hA5) begin failures++; $display("FAIL loop_mosi_seq got %h want a5", mb); end
    checks++; if (uns !== 0) begin failures++; $display("FAIL loop_mosi_stable got %0d changes want 0", uns); end
    @(negedge clk_core);
    checks++;
    if (done !== 1'b0 || sd_mosi !== 1'b1) begin
      failures++; $display("FAIL loop_after got done=%b mosi=%b want 0 1", done, sd_mosi);
    end
  endtask
  task automatic test_div3;
    int bc, lmin, lmax, hmin, hmax, uns;
    logic [7:0] mb;
    logic de, cf, bf;
    div = 8'd3; loop_en = 1'b0; miso_val = 1'b1;
    xfer(8'h00, 1'b0, 1'b0, -1, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++; if (bc !== 64) begin failures++; $display("FAIL div3_busy_len got %0d want 64", bc); end
    checks++;
    if (lmin !== 4 || lmax !== 4 || hmin !== 4 || hmax !== 4) begin
      failures++; $display("FAIL div3_phases got low %0d..%0d high %0d..%0d want 4", lmin, lmax, hmin, hmax);
    end
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL div3_rd got %h want ff", rd_data); end
    checks++; if (de !== 1'b1) begin failures++; $display("FAIL div3_done got %b want 1", de); end
    @(negedge clk_core);
  endtask
  task automatic test_cs;
    int bc, lmin, lmax, hmin, hmax, uns;
    logic [7:0] mb;
    logic de, cf, bf;
    div = 8'd0; loop_en = 1'b1;
    xfer(8'h3C, 1'b1, 1'b0, 5, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++;
    if (cf !== 1'b0 || bf !== 1'b1) begin
      failures++; $display("FAIL cs_with_start got cs_n=%b busy=%b want 0 1", cf, bf);
    end
    checks++; if (bc !== 16) begin failures++; $display("FAIL cs_busy_len got %0d want 16", bc); end
    checks++; if (sd_cs_n !== 1'b0) begin failures++; $display("FAIL cs_ignored got cs_n=%b want 0", sd_cs_n); end
    checks++;
    if (mb !== 8'h3C || rd_data !== 8'h3C) begin
      failures++; $display("FAIL cs_data got mosi=%h rd=%h want 3c 3c", mb, rd_data);
    end
    @(negedge clk_core);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cs_no_queue got busy=%b want 0", busy); end
  endtask
  task automatic test_reset_mid;
    int rises, i, bc, lmin, lmax, hmin, hmax, uns;
    logic prev, done_seen, de, cf, bf;
    logic [7:0] mb;
    div = 8'd1; loop_en = 1'b1;
    wr_data = 8'hC3; wr_stb = 1'b1;
    @(negedge clk_core);
    wr_stb = 1'b0;
    rises = 0; prev = 1'b0; done_seen = 1'b0; i = 0;
    while (i < 200) begin
      if (sd_sck && !prev) rises++;
      prev = sd_sck;
      done_seen |= done;
      if (rises == 4 && !sd_sck) break;
      i++;
      @(negedge clk_core);
    end
    checks++; if (rises !== 4) begin failures++; $display("FAIL rmid_reach_bit4 got %0d rises want 4", rises); end
    reset_n = 1'b0;
    @(negedge clk_core);
    checks++;
    if ({sd_sck, sd_mosi, sd_cs_n, busy, done, rd_data} !== {5'b01100, 8'h00}) begin
      failures++;
      $display("FAIL rmid_values got sck=%b mosi=%b cs_n=%b busy=%b done=%b rd=%h want 0 1 1 0 0 00",
               sd_sck, sd_mosi, sd_cs_n, busy, done, rd_data);
    end
    reset_n = 1'b1;
    @(negedge clk_core);
    done_seen |= done;
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL rmid_no_done got %b want 0", done_seen); end
    xfer(8'h5A, 1'b0, 1'b0, -1, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++;
    if (rd_data !== 8'h5A || de !== 1'b1) begin
      failures++; $display("FAIL rmid_after got rd=%h done=%b want 5a 1", rd_data, de);
    end
    @(negedge clk_core);
  endtask
  task automatic test_back_to_back;
    int bc, lmin, lmax, hmin, hmax, uns;
    logic [7:0] mb;
    logic de, cf, bf;
    div = 8'd2; loop_en = 1'b1;
    xfer(8'h11, 1'b0, 1'b0, -1, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++;
    if (de !== 1'b1 || rd_data !== 8'h11) begin
      failures++; $display("FAIL b2b_first got done=%b rd=%h want 1 11", de, rd_data);
    end
    xfer(8'h81, 1'b0, 1'b0, -1, bc, mb, lmin, lmax, hmin, hmax, uns, de, cf, bf);
    checks++; if (bf !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b want 1", bf); end
    checks++;
    if (bc + 1 !== 49 || de !== 1'b1) begin
      failures++; $display("FAIL b2b_spacing got %0d done=%b want 49 1", bc + 1, de);
    end
    checks++; if (rd_data !== 8'h81) begin failures++; $display("FAIL b2b_rd got %h want 81", rd_data); end
    @(negedge clk_core);
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_div3();
    test_cs();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

Byte-wide SPI master (mode 0, MSB first) that replaces firmware bit-banging of the SD card pins. It sits downstream of the SoC output/input ports and drives `sd_sck`, `sd_mosi`, and `sd_cs_n` directly. Firmware loads a byte and the block shifts it out while shifting a byte in from `sd_miso`. A programmable divisor covers both the slow (≤400 kHz) init phase and the fast data phase.

## Interface

Parameters:
- `DIV_WIDTH`, default 8: width of the half-period divisor.

Ports:
- `clk_core  in  1`: core clock; all logic on its rising edge.
- `reset_n  in  1`: reset, synchronous, active-low.
- `div  in  DIV_WIDTH`: SCK half-period minus one, in `clk_core` cycles. Latched at transfer start.
- `wr_data  in  8`: byte to transmit.
- `wr_stb  in  1`: start a transfer with `wr_data`. Honoured only when idle.
- `cs_set  in  1`: load `cs_val` into chip select. Honoured only when idle.
- `cs_val  in  1`: new `sd_cs_n` level.
- `rd_data  out  8`: last received byte. Holds until the next transfer completes.
- `busy  out  1`: transfer in progress.
- `done  out  1`: one-cycle pulse when `rd_data` is updated.
- `sd_sck  out  1`: SPI clock. Idles low.
- `sd_mosi  out  1`: SPI data out. Idles high.
- `sd_miso  in  1`: SPI data in.
- `sd_cs_n  out  1`: chip select, active-low.

## Operation

- All outputs are registered. Reset values: `sd_sck=0`, `sd_mosi=1`, `sd_cs_n=1`, `busy=0`, `done=0`, `rd_data=8'h00`.
- FSM states: IDLE, LOW, HIGH.
  - IDLE, `wr_stb=1`:
    - latch `div` into the half-period reload;
    - load `wr_data` into the TX shift register;
    - drive `sd_mosi=wr_data[7]`;
    - clear the bit counter and set the half counter to `div`;
    - `busy<=1`, go to LOW.
  - LOW: `sd_sck=0`. Half counter decrements each cycle. At 0:
    - `sd_sck<=1`;
    - shift `sd_miso` into the RX register LSB;
    - reload the half counter;
    - go to HIGH.
  - HIGH: `sd_sck=1`. At counter 0:
    - `sd_sck<=0`;
    - if bit count < 7: present the next TX bit on `sd_mosi`, increment the bit count, reload, go to LOW;
    - else: `rd_data<=RX register`, `done<=1`, `busy<=0`, `sd_mosi<=1`, go to IDLE.
- MISO is sampled on the same `clk_core` edge that raises SCK. It has no synchronizer, because it is timed against our own SCK.
- `cs_set` and `wr_stb` asserted on the same idle cycle: both take effect on the same edge. `sd_cs_n` and the first MOSI bit change together, with SCK still low for a full half-period.
- `wr_stb` or `cs_set` while `busy=1`: ignored entirely, with no queuing. Firmware polls `busy` or `done`.
- A change on `div` mid-transfer has no effect; only the value latched at start is used.
- `reset_n` low mid-transfer: abort. All outputs return to reset values at the next edge, and no `done` pulse is issued.

## Timing

- Strobe sampled at edge T:
  - `busy=1` and MOSI=bit 7 from T+1.
  - Each half-period is exactly `div+1` cycles.
  - SCK rises for bit n (n=0..7) at T+1+(2n+1)(div+1).
- `busy` is high for exactly 16·(div+1) cycles.
- `done` is high for one cycle, coinciding with the first cycle of `busy=0`. `rd_data` is valid from that cycle.
- A new `wr_stb` may be accepted on the cycle `done` is high. Back-to-back byte spacing is 16·(div+1)+1 cycles.
- `div=0` gives SCK = `clk_core`/2. The maximum `div` gives a half-period of 2^DIV_WIDTH cycles.
- The RX register keeps 8 bits: bit 7 is the first sample taken, bit 0 the last.

## Test plan

- Reset: hold `reset_n=0` for 2 cycles. Outputs are `sd_sck=0`, `sd_mosi=1`, `sd_cs_n=1`, `busy=0`, `done=0`, `rd_data=00`.
- Loopback at `div=0`, `sd_miso` tied to `sd_mosi`, `wr_data=A5`:
  - `busy` high for 16 cycles, then `done` for one cycle;
  - `rd_data=A5`;
  - MOSI sequence 1,0,1,0,0,1,0,1, stable across every SCK rise.
- `div=3`, `sd_miso=1`, `wr_data=00`:
  - SCK high and low phases are each 4 cycles;
  - `busy` is high for 64 cycles;
  - `rd_data=FF`.
- Chip select plus transfer:
  - `cs_set=1, cs_val=0` together with `wr_stb` (`wr_data=3C`): `sd_cs_n=0` on the same cycle as `busy=1`.
  - `cs_set=1, cs_val=1` and `wr_stb` (`wr_data=FF`) mid-transfer: both ignored; `sd_cs_n` stays 0 and the transfer completes with the original `3C`.
- Reset mid-transfer: assert `reset_n=0` at bit 4. No `done` pulse; all outputs at reset values one cycle later. A following transfer of `5A` in loopback returns `5A`.
- Back-to-back: issue `wr_stb` (`wr_data=81`) on the `done` cycle of the prior transfer. It is accepted, and the next `done` arrives 16·(div+1)+1 cycles later.
